// File: rtl/bram_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : bram_burst_reader
// Purpose  : Turns {address, length} commands into BRAM byte bursts returned
//            as a valid/ready stream, absorbing the BRAM read latency.
// Revision : 1.0 - initial release
// ============================================================================
module bram_burst_reader #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 8,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4   // power of 2, >= RD_LAT+1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len_m1,
  output logic              mem_rden,
  output logic [ADDR_W-1:0] mem_rdaddress,
  input  logic [DATA_W-1:0] mem_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);

  localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_CNT_W = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_remaining;
  logic [RD_LAT-1:0]   r_tag_valid;
  logic [RD_LAT-1:0]   r_tag_last;
  logic [DATA_W-1:0]   r_fifo_data [FIFO_DEPTH];
  logic                r_fifo_last [FIFO_DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_CNT_W-1:0]  r_fifo_count;
  logic [c_CNT_W-1:0]  w_inflight;
  logic [c_CNT_W-1:0]  w_occupancy;
  logic                w_credit;
  logic                w_issue;
  logic                w_accept;
  logic                w_push;
  logic                w_pop;

  assign w_accept      = (r_state == S_IDLE) && cmd_valid;
  assign w_push        = r_tag_valid[RD_LAT-1];
  assign w_pop         = out_valid && out_ready;
  assign cmd_ready     = (r_state == S_IDLE);
  assign busy          = (r_state != S_IDLE);
  assign mem_rden      = w_issue;
  assign mem_rdaddress = r_addr;
  assign out_valid     = (r_fifo_count != '0);
  assign out_data      = r_fifo_data[r_rd_ptr];
  assign out_last      = r_fifo_last[r_rd_ptr];

  // Credit covers bytes already buffered plus reads still in the BRAM pipe,
  // so every read issued is guaranteed a FIFO slot when its data lands.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_inflight = w_inflight + c_CNT_W'(r_tag_valid[i]);
    end
  end

  assign w_occupancy = r_fifo_count + w_inflight;
  assign w_credit    = (w_occupancy < c_CNT_W'(FIFO_DEPTH));

  always_comb begin
    w_next_state = r_state;
    w_issue      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) w_next_state = S_ISSUE;
      end
      S_ISSUE: begin
        if (w_credit) begin
          w_issue = 1'b1;
          if (r_remaining == '0) w_next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_pop && out_last) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_addr      <= cmd_addr;
        r_remaining <= cmd_len_m1;
      end else if (w_issue) begin
        r_addr      <= r_addr + 1'b1;
        r_remaining <= r_remaining - 1'b1;
      end
    end
  end

  // Tag pipe mirrors the BRAM read pipeline; the exiting tag marks the one
  // cycle in which mem_q holds the requested byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_valid <= '0;
      r_tag_last  <= '0;
    end else begin
      r_tag_valid[0] <= w_issue;
      r_tag_last[0]  <= w_issue && (r_remaining == '0);
      for (int i = 1; i < RD_LAT; i++) begin
        r_tag_valid[i] <= r_tag_valid[i-1];
        r_tag_last[i]  <= r_tag_last[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fifo_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_last[i] <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= mem_q;
        r_fifo_last[r_wr_ptr] <= r_tag_last[RD_LAT-1];
        r_wr_ptr              <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_fifo_count <= r_fifo_count + 1'b1;
        2'b01:   r_fifo_count <= r_fifo_count - 1'b1;
        default: r_fifo_count <= r_fifo_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/bram_burst_reader.md
Name: bram_burst_reader

Overview:
- Single-clock read sequencer that drives the read port of a 4096 x 8 dual-clock BRAM (2-cycle registered read latency).
- Converts one {start address, length} command into a burst of byte reads. Returns the bytes as a valid/ready stream with a last flag.
- Sits directly downstream of the BRAM; its clock also drives the BRAM read clock. Absorbs the fixed read latency with credit counting and a small skid FIFO, so back-pressure never loses data.

Parameters:
- ADDR_W, 12, BRAM address width.
- DATA_W, 8, BRAM data width.
- RD_LAT, 2, cycles from mem_rden sample to valid mem_q.
- FIFO_DEPTH, 4, skid FIFO entries. Must be a power of 2 and >= RD_LAT+1.

Ports:
- clk  in  1  system clock, also the BRAM read clock.
- rst  in  1  asynchronous active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block can accept a command (IDLE only).
- cmd_addr  in  ADDR_W  burst start address.
- cmd_len_m1  in  ADDR_W  burst length minus 1; 0..4095 encodes 1..4096 bytes.
- mem_rden  out  1  BRAM read enable.
- mem_rdaddress  out  ADDR_W  BRAM read address.
- mem_q  in  DATA_W  BRAM read data.
- out_valid  out  1  out_data and out_last are valid.
- out_ready  in  1  consumer accepts the current byte.
- out_data  out  DATA_W  burst byte.
- out_last  out  1  marks the final byte of the burst.
- busy  out  1  a burst is in progress (not IDLE).

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; cmd_ready=1; busy=0; mem_rden=0; mem_rdaddress=0.
  - out_valid=0; out_data=0; out_last=0.
  - FIFO empty; latency pipe tags cleared; all counters 0.
- BRAM timing:
  - Read issued in cycle N (mem_rden=1, address A) yields mem_q=mem[A] in cycle N+RD_LAT only.
  - The BRAM output register shifts every cycle, so the byte must be captured in exactly that cycle.
  - A RD_LAT-deep shift register of {valid, last} tags tracks in-flight reads. The tag exiting the shift register pushes mem_q into the FIFO.
- State IDLE: cmd_ready=1. On cmd_valid&cmd_ready:
  - latch addr=cmd_addr and remaining=cmd_len_m1;
  - go to ISSUE.
  - No read is issued in the accept cycle.
- State ISSUE:
  - Issue a read when credit is available: fifo_count + inflight_count < FIFO_DEPTH, with both counts taken in the current cycle.
  - On issue: mem_rden=1, mem_rdaddress=addr, tag.last=(remaining==0).
  - addr increments modulo 2^ADDR_W, so 4095 wraps to 0. remaining decrements.
  - Issuing the read with remaining==0 moves the block to DRAIN.
  - Without credit: mem_rden=0 and the address holds.
- State DRAIN:
  - No reads are issued.
  - Leave for IDLE in the cycle after the last byte's out_valid&out_ready handshake; cmd_ready rises that cycle.
- Throughput: with out_ready held at 1, one read per cycle and one byte per cycle.
  - First out_valid appears RD_LAT+1 cycles after the first mem_rden, because the FIFO registers its output.
  - A 4096-byte burst completes in 4096+RD_LAT+1 cycles after the first issue.
- FIFO:
  - Push and pop in the same cycle is legal; count is unchanged.
  - Pop when out_valid&out_ready.
  - The credit rule guarantees no push into a full FIFO. Overflow is a design error; the bench asserts it never happens.
- Output stream:
  - out_data and out_last stay stable while out_valid=1 and out_ready=0.
  - out_last=1 on exactly one byte per burst.
- cmd_valid outside IDLE is ignored; cmd_ready=0 outside IDLE.
- Reset mid-burst clears all state immediately. In-flight BRAM data arriving after reset is discarded because the tags are cleared.

Test Plan:
1. Preload mem[i]=i[7:0]; cmd_addr=0x010, len_m1=3, out_ready=1 -> out_data 0x10,0x11,0x12,0x13; out_last only on 0x13; first out_valid 3 cycles after first mem_rden; cmd_ready returns 1 the cycle after the last handshake.
2. Wrap: cmd_addr=0xFFE, len_m1=3 -> mem_rdaddress sequence 0xFFE,0xFFF,0x000,0x001; data 0xFE,0xFF,0x00,0x01.
3. Back-pressure: len_m1=15, out_ready low for 10 cycles mid-burst -> mem_rden stops once FIFO count + in-flight count = 4; no byte lost or duplicated; 16 bytes received in order; overflow assertion never fires.
4. Random out_ready (50%) with full 4096-byte burst (len_m1=0xFFF) from addr 0x800 -> 4096 bytes matching mem[(0x800+k) mod 4096]; single out_last; busy=0 afterwards.
5. Single byte: len_m1=0 at addr 0x123 -> exactly one mem_rden; one output byte 0x23 with out_last=1; cmd_valid pulses during the burst are ignored.
6. Reset mid-burst after 5 bytes issued -> all outputs return to reset values asynchronously; no stale out_valid after rst deasserts; next command (addr 0x000, len_m1=1) returns 0x00,0x01 correctly.
